simd_issue_block: RTL and testbench

- Parametrised successor to the fixed 32-lane bf16 processing block.
- Accepts vector instructions (op, src1, src2, dst, lane mask) over a valid/ready handshake.
- Reads a LANES-wide internal register file, runs one alu_bf16 per lane, and writes results back with a per-lane mask.
- Adds in-order pipelining, RAW-hazard stalling, a host load/readout port and writeback observability, none of which the previous block has.

---
 rtl/simd_pkg.sv | 18 +
 rtl/alu_bf16.sv | 61 ++++++
 rtl/simd_regfile.sv | 40 ++++
 rtl/simd_issue_block.sv | 72 +++++++
 tb/tb_simd_issue_block.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/simd_pkg.sv
// simd_pkg: shared widths, ALU opcodes, pipeline stage record and lane slicing
package simd_pkg;
  localparam int SIMD_LANES = 32;
  localparam int SIMD_BITS = 16;
  localparam int SIMD_AW = 8;
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_MUL = 4'h2;
  localparam logic [3:0] ALU_MAX = 4'h3;
  typedef struct packed {
    logic valid;
    logic [SIMD_AW-1:0] dst;
    logic [SIMD_LANES-1:0] mask;
  } stage_t;
  function automatic logic [SIMD_BITS-1:0] lane(input logic [SIMD_LANES*SIMD_BITS-1:0] v, input int i);
    return v[i*SIMD_BITS +: SIMD_BITS];
  endfunction
endpackage

// File: rtl/alu_bf16.sv
// alu_bf16: one bf16 lane (add/sub/mul/max), round toward zero, subnormals flushed, LAT output registers
module alu_bf16
  import simd_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic [3:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  logic [7:0] ea, eb, ex, ey, ma, mb, mx, my, d;
  logic sa, sb, sx, sy, swap, sticky;
  logic [35:0] t;
  logic [17:0] xf, yt;
  logic [18:0] s;
  logic [4:0] lz;
  logic [6:0] m_add, m_mul;
  logic signed [9:0] e_add, e_mul;
  logic [15:0] p, ka, kb, r_add, r_mul, r_max, y_c;
  logic [15:0] q [LAT];
  // Combinational lane arithmetic; the smaller add operand keeps a sticky bit so subtraction truncates correctly
  always_comb begin
    ea = a[14:7];
    eb = b[14:7];
    ma = (ea != 0) ? {1'b1, a[6:0]} : 8'd0;
    mb = (eb != 0) ? {1'b1, b[6:0]} : 8'd0;
    sa = a[15];
    sb = b[15] ^ (op == ALU_SUB);
    swap = {eb, mb} > {ea, ma};
    {sx, ex, mx} = swap ? {sb, eb, mb} : {sa, ea, ma};
    {sy, ey, my} = swap ? {sa, ea, ma} : {sb, eb, mb};
    d = ex - ey;
    t = {my, 28'd0} >> d;
    yt = t[35:18];
    sticky = |t[17:0];
    xf = {mx, 10'd0};
    s = (sx != sy) ? {1'b0, xf} - {1'b0, yt} - 19'(sticky) : {1'b0, xf} + {1'b0, yt};
    lz = 5'd0;
    for (int i = 0; i < 19; i++) if (s[i]) lz = 5'(18 - i);
    m_add = 7'((s << lz) >> 11);
    e_add = $signed({2'b0, ex}) + 10'sd1 - $signed({5'b0, lz});
    r_add = (s == 0) ? 16'h0000 : (e_add <= 0) ? {sx, 15'h0} : (e_add >= 255) ? {sx, 8'hff, 7'h0} : {sx, e_add[7:0], m_add};
    p = ma * mb;
    m_mul = 7'(p[15] ? p >> 8 : p >> 7);
    e_mul = $signed({2'b0, ea}) + $signed({2'b0, eb}) - 10'sd127 + $signed({9'b0, p[15]});
    r_mul = (ea == 0 || eb == 0) ? 16'h0000 : (e_mul <= 0) ? {a[15] ^ b[15], 15'h0} :
            (e_mul >= 255) ? {a[15] ^ b[15], 8'hff, 7'h0} : {a[15] ^ b[15], e_mul[7:0], m_mul};
    ka = a[15] ? ~a : {1'b1, a[14:0]};
    kb = b[15] ? ~b : {1'b1, b[14:0]};
    r_max = (ka >= kb) ? a : b;
    y_c = (op == ALU_ADD || op == ALU_SUB) ? r_add : (op == ALU_MUL) ? r_mul : (op == ALU_MAX) ? r_max : 16'h0000;
  end
  // Fixed-latency result pipeline
  always_ff @(posedge clk) begin
    q[0] <= y_c;
    for (int k = 1; k < LAT; k++) q[k] <= q[k-1];
  end
  assign y = q[LAT-1];
endmodule

// File: rtl/simd_regfile.sv
// simd_regfile: vector register file, 2 bypassed comb reads, registered host read, masked pipeline + host writes
module simd_regfile #(
  parameter int LANES = 32,
  parameter int BITS = 16,
  parameter int AW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AW-1:0]         ra1,
  input  logic [AW-1:0]         ra2,
  output logic [LANES*BITS-1:0] rd1,
  output logic [LANES*BITS-1:0] rd2,
  input  logic [AW-1:0]         hra,
  output logic [LANES*BITS-1:0] hrd,
  input  logic                  we,
  input  logic [AW-1:0]         wa,
  input  logic [LANES-1:0]      wmask,
  input  logic [LANES*BITS-1:0] wd,
  input  logic                  hwe,
  input  logic [AW-1:0]         hwa,
  input  logic [LANES*BITS-1:0] hwd
);
  logic [LANES*BITS-1:0] mem [2**AW];
  // Write-first reads: a same-cycle pipeline writeback replaces the lanes it enables
  always_comb begin
    rd1 = mem[ra1];
    rd2 = mem[ra2];
    for (int i = 0; i < LANES; i++) begin
      if (we && wmask[i] && wa == ra1) rd1[i*BITS +: BITS] = wd[i*BITS +: BITS];
      if (we && wmask[i] && wa == ra2) rd2[i*BITS +: BITS] = wd[i*BITS +: BITS];
    end
  end
  // Host write is dropped when the pipeline writes the same register in the same cycle
  always_ff @(posedge clk) begin
    if (hwe && !(we && wa == hwa)) mem[hwa] <= hwd;
    for (int i = 0; i < LANES; i++) if (we && wmask[i]) mem[wa][i*BITS +: BITS] <= wd[i*BITS +: BITS];
  end
  // Host readout sees the contents before this edge's writes
  always_ff @(posedge clk) hrd <= rst ? '0 : mem[hra];
endmodule

// File: rtl/simd_issue_block.sv
// simd_issue_block: in-order vector issue with RAW stall, per-lane bf16 ALUs and masked writeback
// stage_t is sized by simd_pkg, so LANES and ADDR_WIDTH must stay at the package widths.
module simd_issue_block
  import simd_pkg::*;
#(
  parameter int LANES = SIMD_LANES,
  parameter int BITS = SIMD_BITS,
  parameter int ADDR_WIDTH = SIMD_AW,
  parameter int ALU_LAT = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [3:0]            instr_op,
  input  logic [ADDR_WIDTH-1:0] instr_src1,
  input  logic [ADDR_WIDTH-1:0] instr_src2,
  input  logic [ADDR_WIDTH-1:0] instr_dst,
  input  logic [LANES-1:0]      instr_mask,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [LANES*BITS-1:0] host_wdata,
  output logic [LANES*BITS-1:0] host_rdata,
  output logic                  wb_valid,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic                  busy
);
  localparam int W = LANES * BITS;
  stage_t st [ALU_LAT+1];
  logic [W-1:0] rd1, rd2, a_q, b_q, res;
  logic [3:0] op_q;
  logic hazard, any_valid;
  // Stall on a source matching any in-flight dst except the writeback stage, which is bypassed
  always_comb begin
    hazard = 1'b0;
    any_valid = 1'b0;
    for (int k = 0; k <= ALU_LAT; k++) begin
      any_valid = any_valid | st[k].valid;
      if (k < ALU_LAT && st[k].valid && (st[k].dst == instr_src1 || st[k].dst == instr_src2)) hazard = 1'b1;
    end
  end
  assign instr_ready = !reset && !hazard;
  assign busy = !reset && any_valid;
  assign wb_valid = !reset && st[ALU_LAT].valid;
  assign wb_addr = st[ALU_LAT].dst;
  // Valid/dst/mask shift register; reset squashes everything in flight
  always_ff @(posedge clock) begin
    if (reset) for (int k = 0; k <= ALU_LAT; k++) st[k] <= '0;
    else begin
      st[0] <= '{instr_valid && instr_ready, instr_dst, instr_mask};
      for (int k = 1; k <= ALU_LAT; k++) st[k] <= st[k-1];
    end
  end
  // Stage 0 operand capture feeding the lanes
  always_ff @(posedge clock) begin
    a_q <= rd1;
    b_q <= rd2;
    op_q <= instr_op;
  end
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    alu_bf16 #(.LAT(ALU_LAT)) u_alu (
      .clk(clock), .op(op_q), .a(lane(a_q, g)), .b(lane(b_q, g)), .y(res[g*BITS +: BITS])
    );
  end
  simd_regfile #(.LANES(LANES), .BITS(BITS), .AW(ADDR_WIDTH)) u_rf (
    .clk(clock), .rst(reset),
    .ra1(instr_src1), .ra2(instr_src2), .rd1(rd1), .rd2(rd2),
    .hra(host_addr), .hrd(host_rdata),
    .we(wb_valid), .wa(st[ALU_LAT].dst), .wmask(st[ALU_LAT].mask), .wd(res),
    .hwe(host_we), .hwa(host_addr), .hwd(host_wdata)
  );
endmodule

// File: tb/tb_simd_issue_block.sv
// tb_simd_issue_block: directed + randomized scoreboard bench against a real-arithmetic bf16 model
module tb_simd_issue_block;
  localparam int L = 32, B = 16, AW = 8, LAT = 1, W = L * B;
  logic clock = 0, reset = 1;
  logic instr_valid = 0, instr_ready, host_we = 0, wb_valid, busy;
  logic [3:0] instr_op = 0;
  logic [AW-1:0] instr_src1 = 0, instr_src2 = 0, instr_dst = 0, host_addr = 0, wb_addr;
  logic [L-1:0] instr_mask = 0;
  logic [W-1:0] host_wdata = 0, host_rdata;
  int checks = 0, errors = 0, cyc = 0, last_wb = -1;
  typedef struct {int dst; int cyc;} exp_t;
  exp_t sb[$];
  logic [W-1:0] mdl [256];

  simd_issue_block #(.LANES(L), .BITS(B), .ADDR_WIDTH(AW), .ALU_LAT(LAT)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_src1(instr_src1), .instr_src2(instr_src2), .instr_dst(instr_dst),
    .instr_mask(instr_mask), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .wb_valid(wb_valid), .wb_addr(wb_addr), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic real bf2r(logic [15:0] v);
    if (v[14:7] == 0) return 0.0;
    return $bitstoreal({v[15], 11'(int'(v[14:7]) + 896), v[6:0], 45'd0});
  endfunction
  function automatic logic [15:0] r2bf(real r);
    logic [63:0] dd;
    int e;
    if (r == 0.0) return 16'h0000;
    dd = $realtobits(r);
    e = int'(dd[62:52]) - 896;
    if (e <= 0) return {dd[63], 15'h0};
    if (e >= 255) return {dd[63], 8'hff, 7'h0};
    return {dd[63], 8'(e), dd[51:45]};
  endfunction
  function automatic logic [15:0] ref_op(logic [3:0] op, logic [15:0] a, logic [15:0] b);
    real x, y;
    x = bf2r(a);
    y = bf2r(b);
    case (op)
      4'h0: return r2bf(x + y);
      4'h1: return r2bf(x - y);
      4'h2: return r2bf(x * y);
      4'h3: return (x >= y) ? a : b;
      default: return 16'h0000;
    endcase
  endfunction

  // monitor: every writeback must match the oldest outstanding issue in address and cycle
  always @(negedge clock) begin : mon
    exp_t e;
    if (wb_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected addr=%0d cycle=%0d", wb_addr, cyc);
      end else begin
        e = sb.pop_front();
        if (int'(wb_addr) != e.dst || cyc != e.cyc) begin
          errors++;
          $display("FAIL wb addr=%0d cycle=%0d want addr=%0d cycle=%0d", wb_addr, cyc, e.dst, e.cyc);
        end
        last_wb = cyc;
      end
    end
  end

  task automatic check(string nm, logic [W-1:0] got, logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic host_write(int a, logic [W-1:0] v);
    host_we = 1;
    host_addr = AW'(a);
    host_wdata = v;
    @(posedge clock); #1;
    host_we = 0;
    mdl[a] = v;
  endtask

  task automatic host_read(int a, output logic [W-1:0] v);
    host_addr = AW'(a);
    @(posedge clock); #1;
    v = host_rdata;
  endtask

  task automatic check_reg(string nm, int a, logic [W-1:0] want);
    logic [W-1:0] v;
    host_read(a, v);
    check(nm, v, want);
  endtask

  task automatic issue(logic [3:0] op, int s1, int s2, int d, logic [L-1:0] m, bit track, output int stalls);
    bit ok;
    logic [W-1:0] nv;
    instr_valid = 1;
    instr_op = op;
    instr_src1 = AW'(s1);
    instr_src2 = AW'(s2);
    instr_dst = AW'(d);
    instr_mask = m;
    ok = 0;
    stalls = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (instr_ready) begin ok = 1; break; end
      stalls++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout dst=%0d", d);
    end else if (track) begin
      sb.push_back('{d, cyc + 1 + LAT});
      nv = mdl[d];
      for (int i = 0; i < L; i++)
        if (m[i]) nv[i*B +: B] = ref_op(op, mdl[s1][i*B +: B], mdl[s2][i*B +: B]);
      mdl[d] = nv;
    end
    @(posedge clock); #1;
    instr_valid = 0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      if (!busy && sb.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout busy=%0b pending=%0d", busy, sb.size());
    end
    @(posedge clock); #1;
  endtask

  function automatic logic [15:0] friendly();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 7'($urandom)};
  endfunction

  initial begin
    logic [W-1:0] v, e;
    int st, st_sum, sel, op, s1, s2, d;
    logic [L-1:0] m;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ready", W'(instr_ready), W'(0));
    check("rst_wb_valid", W'(wb_valid), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_wb_addr", W'(wb_addr), W'(0));
    check("rst_host_rdata", host_rdata, W'(0));
    @(posedge clock); #1;
    reset = 0;

    host_write(1, {L{16'h3F80}});
    host_write(2, {L{16'h4000}});
    issue(4'h0, 1, 2, 3, '1, 1, st);
    wait_idle();
    check_reg("add_basic", 3, {L{16'h4040}});

    host_write(4, '0);
    issue(4'h0, 1, 2, 4, 32'h0000_0005, 1, st);
    wait_idle();
    e = '0;
    e[0 +: 16] = 16'h4040;
    e[32 +: 16] = 16'h4040;
    check_reg("lane_mask", 4, e);

    issue(4'h0, 1, 2, 5, '1, 1, st);
    issue(4'h0, 5, 1, 6, '1, 1, st);
    check("raw_stall_cycles", W'(st), W'(LAT));
    wait_idle();
    check_reg("raw_bypass", 6, {L{16'h4080}});

    st_sum = 0;
    issue(4'h0, 1, 2, 9, '1, 1, st);  st_sum += st;
    issue(4'h1, 2, 1, 10, '1, 1, st); st_sum += st;
    issue(4'h2, 2, 2, 11, '1, 1, st); st_sum += st;
    issue(4'h3, 1, 2, 12, '1, 1, st); st_sum += st;
    check("b2b_no_stall", W'(st_sum), W'(0));
    for (int n = 0; n < 20 && busy; n++) @(negedge clock);
    check("busy_drop_cycle", W'(cyc), W'(last_wb + 1));
    @(posedge clock); #1;
    check_reg("b2b_add", 9, {L{16'h4040}});
    check_reg("b2b_sub", 10, {L{16'h3F80}});
    check_reg("b2b_mul", 11, {L{16'h4080}});
    check_reg("b2b_max", 12, {L{16'h4000}});

    issue(4'h0, 1, 2, 7, '1, 1, st);
    repeat (LAT - 1) @(posedge clock);
    #0;
    host_we = 1;
    host_addr = 7;
    host_wdata = {L{16'h1234}};
    @(posedge clock); #1;
    host_we = 0;
    wait_idle();
    check_reg("collision_same_addr", 7, {L{16'h4040}});

    issue(4'h2, 2, 2, 13, '1, 1, st);
    repeat (LAT - 1) @(posedge clock);
    host_we = 1;
    host_addr = 14;
    host_wdata = {L{16'h1234}};
    @(posedge clock); #1;
    host_we = 0;
    mdl[14] = {L{16'h1234}};
    wait_idle();
    check_reg("dual_write_pipe", 13, {L{16'h4080}});
    check_reg("dual_write_host", 14, {L{16'h1234}});

    host_write(8, {L{16'hAAAA}});
    issue(4'h0, 1, 2, 8, '1, 0, st);
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    @(negedge clock);
    check("squash_busy", W'(busy), W'(0));
    check("squash_ready", W'(instr_ready), W'(1));
    check("squash_rdata", host_rdata, W'(0));
    @(posedge clock); #1;
    repeat (3) @(posedge clock);
    #1;
    check_reg("squash_reg", 8, {L{16'hAAAA}});

    for (int bt = 0; bt < 4; bt++) begin
      for (int r = 0; r < 16; r++) begin
        for (int i = 0; i < L; i++) v[i*B +: B] = friendly();
        host_write(r, v);
      end
      for (int k = 0; k < 24; k++) begin
        op = $urandom_range(0, 3);
        s1 = (op == 3) ? $urandom_range(0, 15) : $urandom_range(0, 7);
        s2 = (op == 3) ? $urandom_range(0, 15) : $urandom_range(0, 7);
        d = $urandom_range(8, 15);
        sel = $urandom_range(0, 3);
        m = (sel == 0) ? '0 : (sel == 1) ? '1 : L'($urandom);
        issue(4'(op), s1, s2, d, m, 1, st);
      end
      wait_idle();
      for (int r = 8; r < 16; r++) check_reg("rand_reg", r, mdl[r]);
    end

    check("sb_drained", W'(sb.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
